// File: rtl/audio_buffer_ctrl.sv
// audio_buffer_ctrl: sample-rate record/playback sequencer between a mic sample stream and a
// single-port sample BRAM. Build macro LOOP_PLAY_EN selects looping playback.
module audio_buffer_ctrl #(
   parameter int unsigned DATA_W  = 12,
   parameter int unsigned ADDR_W  = 15,
   parameter int unsigned DEPTH   = 32000,
   parameter int unsigned CLK_DIV = 6250
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable_write,
   input  logic              enable_read,
   input  logic [DATA_W-1:0] sample_in,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] sample_out,
   output logic              sample_out_valid,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned LEN_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CLK_DIV - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam logic [LEN_W-1:0]  FULL_LEN = LEN_W'(DEPTH);

   typedef enum logic [1:0] {StIdle, StRec, StPlay, StHold} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] sample_out_q, sample_out_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [LEN_W-1:0]  rec_len_q, rec_len_d;
   logic              rd_pend_q, rd_pend_d;

   logic              tick;
   logic [LEN_W-1:0]  addr_inc;
   logic [LEN_W-1:0]  written;
   logic              last_play;

   assign tick      = (cnt_q == LAST_CNT);
   assign addr_inc  = {1'b0, mem_addr_q} + LEN_W'(1);
   // The index only advances the clk after a write, so a write in flight still counts.
   assign written   = {1'b0, mem_addr_q} + LEN_W'(mem_we_q);
   assign last_play = (addr_inc == rec_len_q);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mem_addr_d   = mem_addr_q;
      mem_we_d     = 1'b0;
      mem_wdata_d  = mem_wdata_q;
      sample_out_d = sample_out_q;
      valid_d      = 1'b0;
      done_d       = 1'b0;
      rec_len_d    = rec_len_q;
      rd_pend_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (enable_write) begin
               state_d    = StRec;
               mem_addr_d = '0;
            end else if (enable_read) begin
               state_d    = StPlay;
               mem_addr_d = '0;
            end
         end

         StRec: begin
            if (!enable_write) begin
               state_d   = StIdle;
               cnt_d     = '0;
               rec_len_d = written;
            end else begin
               cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
               if (mem_we_q) begin
                  mem_addr_d = mem_addr_q + ADDR_W'(1);
               end
               if (tick) begin
                  mem_we_d    = 1'b1;
                  mem_wdata_d = sample_in;
                  if (mem_addr_q == LAST_IDX) begin
                     done_d    = 1'b1;
                     rec_len_d = FULL_LEN;
                     state_d   = StHold;
                     cnt_d     = '0;
                  end
               end
            end
         end

         StPlay: begin
            if (!enable_read) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (rec_len_q == '0) begin
               done_d  = 1'b1;
               state_d = StHold;
               cnt_d   = '0;
            end else begin
               cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
               // Address is already stable on index before the tick, so the BRAM output
               // is valid for capture one clk after the tick.
               if (tick) begin
                  rd_pend_d = 1'b1;
               end
               if (rd_pend_q) begin
                  sample_out_d = mem_rdata;
                  valid_d      = 1'b1;
                  if (last_play) begin
`ifdef LOOP_PLAY_EN
                     mem_addr_d = '0;
`else
                     done_d  = 1'b1;
                     state_d = StHold;
                     cnt_d   = '0;
`endif
                  end else begin
                     mem_addr_d = mem_addr_q + ADDR_W'(1);
                  end
               end
            end
         end

         StHold: begin
            cnt_d = '0;
            if (!enable_write && !enable_read) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d == StRec) || (state_d == StPlay);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
         sample_out_q <= '0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         rec_len_q    <= '0;
         rd_pend_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
         sample_out_q <= sample_out_d;
         valid_q      <= valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         rec_len_q    <= rec_len_d;
         rd_pend_q    <= rd_pend_d;
      end
   end

   assign mem_addr         = mem_addr_q;
   assign mem_we           = mem_we_q;
   assign mem_wdata        = mem_wdata_q;
   assign sample_out       = sample_out_q;
   assign sample_out_valid = valid_q;
   assign busy             = busy_q;
   assign done             = done_q;

endmodule

// File: tb/tb_audio_buffer_ctrl.sv
// tb_audio_buffer_ctrl: directed and randomized record/playback bench with a behavioural
// model compared every cycle and a BRAM model with one-clk read latency.
module tb_audio_buffer_ctrl;

   localparam int unsigned DATA_W  = 12;
   localparam int unsigned ADDR_W  = 3;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned CLK_DIV = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              enable_write = 1'b0;
   logic              enable_read = 1'b0;
   logic [DATA_W-1:0] sample_in = '0;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic [DATA_W-1:0] sample_out;
   logic              sample_out_valid;
   logic              busy;
   logic              done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   audio_buffer_ctrl #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .CLK_DIV(CLK_DIV)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .enable_write    (enable_write),
      .enable_read     (enable_read),
      .sample_in       (sample_in),
      .mem_addr        (mem_addr),
      .mem_we          (mem_we),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .sample_out      (sample_out),
      .sample_out_valid(sample_out_valid),
      .busy            (busy),
      .done            (done)
   );

   // Synchronous-read BRAM
   logic [DATA_W-1:0] bram [2**ADDR_W];
   initial for (int i = 0; i < 2**ADDR_W; i++) bram[i] = '0;
   always @(posedge clk) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural model: k counts clks since entering REC/PLAY; writes land on every
   // CLK_DIV-th clk, captures one clk after each such tick.
   typedef enum int {MIdle, MRec, MPlay, MHold} mode_t;
   mode_t             mode;
   int                k, m_written, m_played, m_len;
   logic [DATA_W-1:0] m_mem [DEPTH];
   logic [ADDR_W-1:0] e_addr;
   logic              e_we, e_valid, e_busy, e_done;
   logic [DATA_W-1:0] e_wdata, e_sout;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode = MIdle; k = 0; m_written = 0; m_played = 0; m_len = 0;
         e_addr = '0; e_we = 0; e_valid = 0; e_busy = 0; e_done = 0;
         e_wdata = '0; e_sout = '0;
      end else begin
         e_we = 0; e_valid = 0; e_done = 0;
         case (mode)
            MIdle: begin
               if (enable_write) begin
                  mode = MRec; k = 0; m_written = 0; e_addr = '0;
               end else if (enable_read) begin
                  mode = MPlay; k = 0; m_played = 0; e_addr = '0;
               end
            end
            MRec: begin
               if (!enable_write) begin
                  mode = MIdle; m_len = m_written;
               end else begin
                  k++;
                  e_addr = ADDR_W'(m_written);
                  if (k % CLK_DIV == 0) begin
                     e_we = 1; e_wdata = sample_in;
                     m_mem[m_written] = sample_in;
                     m_written++;
                     if (m_written == DEPTH) begin
                        e_done = 1; m_len = DEPTH; mode = MHold;
                     end
                  end
               end
            end
            MPlay: begin
               if (!enable_read) begin
                  mode = MIdle;
               end else if (m_len == 0) begin
                  e_done = 1; mode = MHold;
               end else begin
                  k++;
                  if (k > 1 && k % CLK_DIV == 1) begin
                     e_valid = 1;
                     e_sout = m_mem[m_played % m_len];
                     m_played++;
`ifndef LOOP_PLAY_EN
                     if (m_played == m_len) begin
                        e_done = 1; mode = MHold;
                     end
`endif
                  end
                  if (mode == MPlay) e_addr = ADDR_W'(m_played % m_len);
               end
            end
            MHold: begin
               if (!enable_write && !enable_read) mode = MIdle;
            end
            default: mode = MIdle;
         endcase
         e_busy = (mode == MRec) || (mode == MPlay);
      end
   end

   // Event logs for the directed literal checks
   int                we_cyc[$];
   logic [ADDR_W-1:0] we_addr[$];
   logic [DATA_W-1:0] we_data[$];
   int                val_cyc[$];
   logic [ADDR_W-1:0] val_addr[$];
   logic [DATA_W-1:0] val_data[$];
   int                done_cyc[$];
   logic [ADDR_W-1:0] prev_addr = '0;

   always @(negedge clk) begin
      cyc++;
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      chk("sample_out", 32'(sample_out), 32'(e_sout));
      chk("sample_out_valid", 32'(sample_out_valid), 32'(e_valid));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      if (mem_we) begin
         we_cyc.push_back(cyc); we_addr.push_back(mem_addr); we_data.push_back(mem_wdata);
      end
      if (sample_out_valid) begin
         val_cyc.push_back(cyc); val_addr.push_back(prev_addr); val_data.push_back(sample_out);
      end
      if (done) done_cyc.push_back(cyc);
      prev_addr = mem_addr;
   end

   task automatic clear_logs();
      we_cyc.delete(); we_addr.delete(); we_data.delete();
      val_cyc.delete(); val_addr.delete(); val_data.delete(); done_cyc.delete();
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle_all();
      enable_write = 0; enable_read = 0;
      step(3);
   endtask

   initial begin
      step(3);
      reset = 1;
      step(2);

      // 1: async reset mid-REC, then playback of an empty take
      enable_write = 1;
      step(6);
      #2 reset = 0;
      #1;
      chk("t1_rst_addr", 32'(mem_addr), 0);
      chk("t1_rst_we", 32'(mem_we), 0);
      chk("t1_rst_wdata", 32'(mem_wdata), 0);
      chk("t1_rst_sout", 32'(sample_out), 0);
      chk("t1_rst_valid", 32'(sample_out_valid), 0);
      chk("t1_rst_busy", 32'(busy), 0);
      chk("t1_rst_done", 32'(done), 0);
      enable_write = 0;
      step(1);
      reset = 1;
      step(1);
      clear_logs();
      enable_read = 1;
      step(4);
      chk("t1_done_count", done_cyc.size(), 1);
      chk("t1_valid_count", val_cyc.size(), 0);
      idle_all();

      // 2: full take, samples 0x101..0x404
      clear_logs();
      enable_write = 1;
      for (int c = 0; c < 30; c++) begin
         sample_in = DATA_W'(32'h101 * (c / 4));
         step(1);
      end
      chk("t2_write_count", we_cyc.size(), 4);
      for (int i = 0; i < we_cyc.size() && i < 4; i++) begin
         chk("t2_addr", 32'(we_addr[i]), i);
         chk("t2_data", 32'(we_data[i]), 32'h101 * (i + 1));
         if (i > 0) chk("t2_spacing", we_cyc[i] - we_cyc[i-1], 4);
      end
      chk("t2_done_count", done_cyc.size(), 1);
      if (done_cyc.size() == 1 && we_cyc.size() == 4) chk("t2_done_with_4th", done_cyc[0], we_cyc[3]);
      chk("t2_busy_held", 32'(busy), 0);
      idle_all();

`ifndef LOOP_PLAY_EN
      // 3: single-shot playback of the take
      clear_logs();
      enable_read = 1;
      step(30);
      chk("t3_valid_count", val_cyc.size(), 4);
      for (int i = 0; i < val_cyc.size() && i < 4; i++) begin
         chk("t3_addr", 32'(val_addr[i]), i);
         chk("t3_data", 32'(val_data[i]), 32'h101 * (i + 1));
      end
      chk("t3_done_count", done_cyc.size(), 1);
      if (done_cyc.size() == 1 && val_cyc.size() == 4) chk("t3_done_with_4th", done_cyc[0], val_cyc[3]);
      chk("t3_busy_held", 32'(busy), 0);
      idle_all();
`endif

      // 4: simultaneous requests, record wins
      clear_logs();
      enable_write = 1; enable_read = 1;
      for (int c = 0; c < 20; c++) begin
         sample_in = DATA_W'($urandom);
         step(1);
      end
      chk("t4_write_count", we_cyc.size(), 4);
      chk("t4_valid_count", val_cyc.size(), 0);
      idle_all();

      // 5: record aborted after two writes, then play those two
      clear_logs();
      enable_write = 1;
      for (int c = 0; c < 10; c++) begin
         sample_in = DATA_W'(32'h500 + c);
         step(1);
      end
      enable_write = 0;
      step(3);
      chk("t5_write_count", we_cyc.size(), 2);
      chk("t5_no_done", done_cyc.size(), 0);
      clear_logs();
      enable_read = 1;
      step(30);
`ifndef LOOP_PLAY_EN
      chk("t5_valid_count", val_cyc.size(), 2);
      chk("t5_done_count", done_cyc.size(), 1);
`endif
      for (int i = 0; i < val_cyc.size() && i < 2; i++) begin
         chk("t5_data", 32'(val_data[i]), 32'h504 + 4 * i);
      end
      idle_all();

`ifdef LOOP_PLAY_EN
      // 6: looping playback over a 4-sample take
      enable_write = 1;
      step(20);
      idle_all();
      clear_logs();
      enable_read = 1;
      step(42);
      chk("t6_valid_count", val_cyc.size(), 10);
      for (int i = 0; i < val_cyc.size() && i < 10; i++) begin
         chk("t6_addr", 32'(val_addr[i]), i % 4);
      end
      chk("t6_no_done", done_cyc.size(), 0);
      idle_all();
`endif

      // Randomized enable patterns with occasional async resets
      for (int seg = 0; seg < 300; seg++) begin
         int r, len;
         r = $urandom_range(0, 3);
         len = $urandom_range(1, 40);
         enable_write = r[0];
         enable_read  = r[1];
         for (int c = 0; c < len; c++) begin
            sample_in = DATA_W'($urandom);
            step(1);
         end
         if ($urandom_range(0, 49) == 0) begin
            #2 reset = 0;
            step(1);
            reset = 1;
         end
      end
      idle_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
